// File: rtl/dm_block_engine.sv
// dm_block_engine: data-memory bus initiator for block copy, fill and verify-against-pattern
module dm_block_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [15:0]      src,
    input  logic [15:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      pattern,
    output logic [15:0]      addr,
    output logic             re,
    output logic             we,
    output logic [15:0]      wrt_data,
    input  logic [15:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      err_cnt,
    output logic [15:0]      fail_addr
);
    typedef enum logic [2:0] {IDLE, RD, WR, CMP, FIN} state_t;

    state_t           state, nxt;
    logic [1:0]       md;
    logic [15:0]      s_base, d_base, pat, rdq;
    logic [LEN_W-1:0] n, i, i_nxt;
    logic [15:0]      sb, db, pat_v, a_nxt;
    logic [1:0]       mdv;
    logic             accept, last;

    // while idle the operands come straight from the ports so the first bus cycle follows start by one clock
    assign accept = state == IDLE && start;
    assign sb     = state == IDLE ? src : s_base;
    assign db     = state == IDLE ? dst : d_base;
    assign mdv    = state == IDLE ? mode : md;
    assign pat_v  = state == IDLE ? pattern : pat;
    assign last   = i == n - 1'b1;
    assign a_nxt  = (nxt == WR || mdv == 2'b10 ? db : sb) + 16'(i_nxt);

    // next state and next word index
    always_comb begin
        nxt   = state;
        i_nxt = i;
        case (state)
            IDLE: if (start) begin
                nxt   = (len == '0 || mode == 2'b11) ? FIN : (mode == 2'b01 ? WR : RD);
                i_nxt = '0;
            end
            RD:  nxt = md == 2'b10 ? CMP : WR;
            WR: begin
                nxt   = last ? FIN : (md == 2'b01 ? WR : RD);
                i_nxt = i + 1'b1;
            end
            CMP: begin
                nxt   = last ? FIN : RD;
                i_nxt = i + 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // state, operand latches and registered bus/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i         <= '0;
            n         <= '0;
            md        <= 2'b00;
            s_base    <= 16'h0;
            d_base    <= 16'h0;
            pat       <= 16'h0;
            rdq       <= 16'h0;
            addr      <= 16'h0;
            re        <= 1'b0;
            we        <= 1'b0;
            wrt_data  <= 16'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 16'h0;
            fail_addr <= 16'h0;
        end else begin
            state <= nxt;
            i     <= i_nxt;
            re    <= nxt == RD;
            we    <= nxt == WR;
            busy  <= nxt != IDLE;
            done  <= nxt == FIN;
            if (nxt == RD || nxt == WR)
                addr <= a_nxt;
            if (nxt == WR)
                wrt_data <= mdv == 2'b01 ? pat_v : rd_data;
            if (state == RD)
                rdq <= rd_data;
            if (accept) begin
                md        <= mode;
                s_base    <= src;
                d_base    <= dst;
                n         <= len;
                pat       <= pattern;
                err       <= mode == 2'b11;
                err_cnt   <= 16'h0;
                fail_addr <= 16'h0;
            end
            if (state == CMP && rdq != pat) begin
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'h0) begin
                    fail_addr <= addr;
                    err       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_block_engine.sv
// tb_dm_block_engine: scoreboard bench for dm_block_engine against a behavioural data memory
module tb_dm_block_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] src = 16'h0, dst = 16'h0, len = 16'h0, pattern = 16'h0;
    logic [15:0] addr, wrt_data, err_cnt, fail_addr;
    logic [15:0] rd_data = 16'h0;
    logic        re, we, busy, done, err;

    logic [15:0] mem [0:65535];
    logic [9:0]  ledr = 10'h0;
    logic [15:0] sw = 16'h5A5A;
    logic        poke_en = 1'b0;
    logic [15:0] poke_a = 16'h0, poke_d = 16'h0;

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    dm_block_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .addr(addr), .re(re), .we(we), .wrt_data(wrt_data),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
        .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory accessed in the clk-low phase; 0xC000 drives LEDR, 0xC001 reads SW
    always @(negedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        if (we) begin
            mem[addr] <= wrt_data;
            if (addr == 16'hC000) ledr <= wrt_data[9:0];
        end
        if (re) rd_data <= addr == 16'hC001 ? sw : mem[addr];
    end

    // bus monitor: every active bus cycle is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && (re || we)) begin
            chk("re_we_excl", 64'(re && we), 64'd0);
            if (q.size() == 0)
                chk("bus_extra", 64'd1, 64'd0);
            else
                chk("bus", 64'({we, addr, we ? wrt_data : 16'h0}), 64'(q.pop_front()));
        end
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(negedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] p);
        for (int k = 0; k < int'(n) && m != 2'b11; k++) begin
            if (m == 2'b00) begin
                q.push_back('{1'b0, s + 16'(k), 16'h0});
                q.push_back('{1'b1, d + 16'(k), mem[s + 16'(k)]});
            end else if (m == 2'b01)
                q.push_back('{1'b1, d + 16'(k), p});
            else
                q.push_back('{1'b0, d + 16'(k), 16'h0});
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] n, input logic [15:0] p, input int pulse);
        int exp_lat, cyc;
        exp_lat = (n == 0 || m == 2'b11) ? 1 : (m == 2'b01 ? int'(n) + 1 : 2 * int'(n) + 1);
        push_exp(m, s, d, n, p);
        @(negedge clk);
        mode = m; src = s; dst = d; len = n; pattern = p; start = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = cyc == pulse;
            if (cyc == pulse) begin
                mode = 2'b01;
                dst  = 16'h0700;
            end
            if (done) break;
        end
        start = 1'b0;
        chk("done_latency", 64'(cyc), 64'(exp_lat));
        chk("busy_at_done", 64'(busy), 64'd1);
        chk("sb_drained", 64'(q.size()), 64'd0);
        @(negedge clk);
        chk("idle_after", 64'({busy, done, re, we}), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_bus", 64'({addr, re, we, wrt_data}), 64'd0);
        chk("rst_status", 64'({busy, done, err, err_cnt, fail_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(2'b01, 16'h0, 16'h0100, 16'd4, 16'hA5A5, 0);
        for (int k = 0; k < 4; k++) chk("fill_rb", 64'(mem[16'h0100 + 16'(k)]), 64'hA5A5);

        poke(16'h0010, 16'h1111);
        poke(16'h0011, 16'h2222);
        poke(16'h0012, 16'h3333);
        run(2'b00, 16'h0010, 16'h0200, 16'd3, 16'h0, 0);
        chk("copy_rb0", 64'(mem[16'h0200]), 64'h1111);
        chk("copy_rb1", 64'(mem[16'h0201]), 64'h2222);
        chk("copy_rb2", 64'(mem[16'h0202]), 64'h3333);

        run(2'b00, 16'h0010, 16'h0210, 16'd3, 16'h0, 3);
        chk("copy_pulse_rb0", 64'(mem[16'h0210]), 64'h1111);
        chk("copy_pulse_rb2", 64'(mem[16'h0212]), 64'h3333);

        run(2'b10, 16'h0, 16'h0100, 16'd4, 16'hA5A5, 0);
        chk("verify_ok_err", 64'({err, err_cnt, fail_addr}), 64'd0);

        run(2'b01, 16'h0, 16'h0300, 16'd8, 16'h0000, 0);
        poke(16'h0302, 16'hDEAD);
        poke(16'h0305, 16'h0001);
        run(2'b10, 16'h0, 16'h0300, 16'd8, 16'h0000, 0);
        chk("verify_err", 64'(err), 64'd1);
        chk("verify_cnt", 64'(err_cnt), 64'd2);
        chk("verify_fail_addr", 64'(fail_addr), 64'h0302);

        run(2'b01, 16'h0, 16'hBFFF, 16'd3, 16'h03FF, 0);
        chk("ledr", 64'(ledr), 64'h3FF);
        chk("err_cleared", 64'({err, err_cnt}), 64'd0);
        run(2'b10, 16'h0, 16'hC001, 16'd1, 16'h5A5A, 0);
        chk("verify_sw", 64'(err), 64'd0);

        run(2'b01, 16'h0, 16'hFFFE, 16'd3, 16'h0BAD, 0);
        chk("wrap_rb", 64'(mem[16'h0000]), 64'h0BAD);

        run(2'b01, 16'h0, 16'h0500, 16'd0, 16'h1234, 0);
        run(2'b11, 16'h0, 16'h0500, 16'd4, 16'h1234, 0);
        chk("reserved_err", 64'(err), 64'd1);

        push_exp(2'b01, 16'h0, 16'h0400, 16'd16, 16'hEEEE);
        @(negedge clk);
        mode = 2'b01; dst = 16'h0400; len = 16'd16; pattern = 16'hEEEE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("we_before_rst", 64'({we, busy}), 64'b11);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({we, re, busy, done}), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(2'b01, 16'h0, 16'h0400, 16'd4, 16'h7777, 0);
        for (int k = 0; k < 4; k++) chk("post_rst_rb", 64'(mem[16'h0400 + 16'(k)]), 64'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
